// File: rtl/seq_mul_shl.sv
// Iterative shift-and-add unsigned multiplier built around an external SHL.
// One bit of b is consumed per cycle, LSB first, giving a 2*DATAWIDTH product.
module seq_mul_shl #(
   parameter int DATAWIDTH = 8
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     start,
   input  logic [DATAWIDTH-1:0]     a,
   input  logic [DATAWIDTH-1:0]     b,
   output logic                     busy,
   output logic                     done,
   output logic [2*DATAWIDTH-1:0]   prod,
   output logic [2*DATAWIDTH-1:0]   shl_a,
   output logic [2*DATAWIDTH-1:0]   shl_sh_amt,
   input  logic [2*DATAWIDTH-1:0]   shl_d
);

   localparam int CW = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                  state, state_n;
   logic [DATAWIDTH-1:0]    a_r, a_n;
   logic [DATAWIDTH-1:0]    b_r, b_n;
   logic [2*DATAWIDTH-1:0]  acc, acc_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic [2*DATAWIDTH-1:0]  prod_n;
   logic                    done_n;
   logic [2*DATAWIDTH-1:0]  sum;

   // The shifter sees only registers, so there is no loop through SHL.
   assign shl_a      = {{DATAWIDTH{1'b0}}, a_r};
   assign shl_sh_amt = {{(2*DATAWIDTH-CW){1'b0}}, cnt};
   assign sum        = b_r[cnt] ? (acc + shl_d) : acc;
   assign busy       = (state == RUN);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= IDLE;
         a_r   <= '0;
         b_r   <= '0;
         acc   <= '0;
         cnt   <= '0;
         prod  <= '0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         a_r   <= a_n;
         b_r   <= b_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
         prod  <= prod_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      a_n     = a_r;
      b_n     = b_r;
      acc_n   = acc;
      cnt_n   = cnt;
      prod_n  = prod;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               a_n     = a;
               b_n     = b;
               acc_n   = '0;
               cnt_n   = '0;
               state_n = RUN;
            end
         end
         RUN: begin
            acc_n = sum;
            cnt_n = cnt + CW'(1);
            // The final iteration publishes the sum including its own add.
            if (cnt == LAST) begin
               prod_n  = sum;
               done_n  = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_seq_mul_shl.sv
// Bench for seq_mul_shl: 8-bit and 4-bit instances share stimulus and are
// checked every cycle against an operation-level model, plus literal results.
module tb_seq_mul_shl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        start;
   logic [7:0]  a, b;

   logic        busy8, done8;
   logic [15:0] prod8, shl_a8, shl_sh_amt8, shl_d8;
   logic        busy4, done4;
   logic [7:0]  prod4, shl_a4, shl_sh_amt4, shl_d4;

   int total = 0;
   int passed = 0;

   // Model state per instance: index 0 is DATAWIDTH=8, index 1 is DATAWIDTH=4.
   int m_busy[2], m_done[2], m_left[2], m_a[2], m_b[2], m_prod[2];

   always #5 Clk = ~Clk;

   assign shl_d8 = shl_a8 << shl_sh_amt8;
   assign shl_d4 = shl_a4 << shl_sh_amt4;

   seq_mul_shl #(.DATAWIDTH(8)) dut8 (
      .Clk(Clk), .Rst(Rst), .start(start), .a(a), .b(b),
      .busy(busy8), .done(done8), .prod(prod8),
      .shl_a(shl_a8), .shl_sh_amt(shl_sh_amt8), .shl_d(shl_d8)
   );

   seq_mul_shl #(.DATAWIDTH(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .start(start), .a(a[3:0]), .b(b[3:0]),
      .busy(busy4), .done(done4), .prod(prod4),
      .shl_a(shl_a4), .shl_sh_amt(shl_sh_amt4), .shl_d(shl_d4)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   // Operation-level model: an accepted op takes w edges and yields a*b.
   always @(posedge Clk) begin
      for (int k = 0; k < 2; k++) begin
         int w;
         int mask;
         w    = (k == 0) ? 8 : 4;
         mask = (1 << w) - 1;
         if (Rst) begin
            m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0;
            m_a[k] = 0; m_b[k] = 0; m_prod[k] = 0;
         end else begin
            m_done[k] = 0;
            if (m_busy[k] != 0) begin
               m_left[k]--;
               if (m_left[k] == 0) begin
                  m_busy[k] = 0;
                  m_done[k] = 1;
                  m_prod[k] = m_a[k] * m_b[k];
               end
            end else if (start) begin
               m_busy[k] = 1;
               m_left[k] = w;
               m_a[k]    = int'(a) & mask;
               m_b[k]    = int'(b) & mask;
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(posedge Clk) begin
      #2;
      for (int k = 0; k < 2; k++) begin
         logic        o_busy, o_done;
         logic [15:0] o_prod, o_sha, o_amt;
         int          w;
         w      = (k == 0) ? 8 : 4;
         o_busy = (k == 0) ? busy8 : busy4;
         o_done = (k == 0) ? done8 : done4;
         o_prod = (k == 0) ? prod8 : {8'b0, prod4};
         o_sha  = (k == 0) ? shl_a8 : {8'b0, shl_a4};
         o_amt  = (k == 0) ? shl_sh_amt8 : {8'b0, shl_sh_amt4};
         checkOutput($sformatf("busy%0d", w), 32'(o_busy), 32'(m_busy[k]));
         checkOutput($sformatf("done%0d", w), 32'(o_done), 32'(m_done[k]));
         checkOutput($sformatf("prod%0d", w), 32'(o_prod), 32'(m_prod[k]));
         checkOutput($sformatf("shl_a%0d", w), 32'(o_sha), 32'(m_a[k]));
         checkOutput($sformatf("sh_amt%0d", w), 32'(o_amt),
                     (m_busy[k] != 0) ? 32'(w - m_left[k]) : 32'd0);
         checkOutput($sformatf("busy_done_excl%0d", w), 32'(o_busy & o_done), 32'd0);
      end
   end

   task automatic waitDone(output int lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge Clk); #3;
         lat++;
         if (done8) break;
      end
      checkOutput("done_timeout", 32'(done8), 32'd1);
   endtask

   // Issues one 8-bit op, tracks the sh_amt sweep and the done/prod result.
   task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib, input logic [15:0] exp);
      @(negedge Clk);
      a = ia; b = ib; start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      #2;
      for (int i = 0; i < 8; i++) begin
         checkOutput("lit_sh_amt", 32'(shl_sh_amt8), 32'(i));
         checkOutput("lit_busy", 32'(busy8), 32'd1);
         @(posedge Clk); #3;
      end
      checkOutput("lit_done", 32'(done8), 32'd1);
      checkOutput("lit_busy_off", 32'(busy8), 32'd0);
      checkOutput("lit_prod", 32'(prod8), 32'(exp));
      @(posedge Clk); #3;
      checkOutput("lit_done_clear", 32'(done8), 32'd0);
      checkOutput("lit_prod_hold", 32'(prod8), 32'(exp));
   endtask

   initial begin
      int lat;
      Rst = 1'b1; start = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge Clk);
      #3;
      checkOutput("rst_busy", 32'(busy8), 32'd0);
      checkOutput("rst_done", 32'(done8), 32'd0);
      checkOutput("rst_prod", 32'(prod8), 32'd0);
      checkOutput("rst_shl_a", 32'(shl_a8), 32'd0);
      checkOutput("rst_sh_amt", 32'(shl_sh_amt8), 32'd0);
      Rst = 1'b0;

      applyStimulus(8'd3, 8'd5, 16'd15);
      applyStimulus(8'd255, 8'd255, 16'hFE01);
      applyStimulus(8'd0, 8'd200, 16'd0);
      applyStimulus(8'd200, 8'd0, 16'd0);

      // start held through RUN with operands changed after acceptance
      @(negedge Clk);
      a = 8'd7; b = 8'd6; start = 1'b1;
      @(posedge Clk); #1;
      a = 8'd9; b = 8'd9;
      waitDone(lat);
      checkOutput("hold_lat", 32'(lat), 32'd8);
      checkOutput("hold_prod", 32'(prod8), 32'd42);
      @(posedge Clk); #1;
      start = 1'b0;
      waitDone(lat);
      checkOutput("b2b_lat", 32'(lat), 32'd8);
      checkOutput("b2b_prod", 32'(prod8), 32'd81);

      // reset in the middle of an operation
      @(negedge Clk);
      a = 8'd12; b = 8'd11; start = 1'b1;
      @(posedge Clk); #1;
      start = 1'b0;
      repeat (3) @(posedge Clk);
      #1 Rst = 1'b1;
      @(posedge Clk); #1;
      Rst = 1'b0;
      #2;
      checkOutput("abort_busy", 32'(busy8), 32'd0);
      checkOutput("abort_done", 32'(done8), 32'd0);
      checkOutput("abort_prod", 32'(prod8), 32'd0);
      repeat (10) @(posedge Clk);
      applyStimulus(8'd12, 8'd11, 16'd132);

      // back-to-back random operations on both widths
      for (int n = 0; n < 300; n++) begin
         @(negedge Clk);
         a = 8'($urandom);
         b = 8'($urandom);
         start = ($urandom_range(0, 3) != 0);
      end
      @(negedge Clk);
      start = 1'b0;
      repeat (12) @(posedge Clk);
      #4;
      $display("[TB] %0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
